dsu_sram_upload: RTL and testbench
==================================

# dsu_sram_upload

Backdoor SRAM upload engine for the DSU: the read-side counterpart of the UART download path, which writes received bytes into instruction SRAM. On a start request it reads a block of 32-bit words from IOCM SRAM and streams them byte by byte to the host through the DSU UART transmitter (`dsu_Tx` handshake: `TxD_start` / `TxD_busy`). It sits beside `dsu_uartlite` and shares the SRAM port with it; the SRAM mux selects this block while `upload_busy` is high.

## Interface
- `ADDR_BW`, 13: SRAM word-address width; matches `IOCM_Word_BW`.

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `upload_start`  in  1  one-cycle request; sampled only in IDLE
- `upload_base`  in  ADDR_BW  first word address; latched on accepted start
- `upload_len`  in  ADDR_BW+1  number of words; latched on accepted start
- `sram_ce`  out  1  SRAM read enable, one cycle per word
- `sram_addr`  out  ADDR_BW  SRAM word address
- `sram_rdata`  in  32  read data, valid exactly one cycle after `sram_ce`
- `tx_start`  out  1  one-cycle pulse to transmitter
- `tx_data`  out  8  byte to send; stable from `tx_start` until `tx_busy` falls
- `tx_busy`  in  1  transmitter busy; rises the cycle after `tx_start`
- `upload_busy`  out  1  high from accepted start until done
- `upload_done`  out  1  one-cycle pulse at completion

## Operation
- FSM states: IDLE, RD, CAP, TX_ARM, TX_GAP, TX_WAIT, NEXT, (CSUM, CSUM_GAP, CSUM_WAIT with checksum), DONE.
- IDLE: on `upload_start`, latch base/len and go to RD. If len==0, go to DONE directly; no SRAM access and no bytes are sent.
- RD: `sram_ce`=1, `sram_addr`=current address; go to CAP.
- CAP: capture `sram_rdata` into a 32-bit shift register and set byte index=0; go to TX_ARM.
- TX_ARM: wait while `tx_busy`=1. When `tx_busy`=0, pulse `tx_start` with `tx_data`=shift[31:24] and go to TX_GAP. Bytes go out big-endian: [31:24], [23:16], [15:8], [7:0].
- TX_GAP: one cycle; `tx_busy` is ignored. Go to TX_WAIT.
- TX_WAIT: when `tx_busy`=0, shift left 8. If index<3, increment index and go to TX_ARM; else go to NEXT.
- NEXT: increment address modulo 2^ADDR_BW (wraps 2^ADDR_BW-1 → 0) and decrement remaining count. If remaining becomes 0, go to DONE (or CSUM); else go to RD.
- DONE: pulse `upload_done`, drop `upload_busy`, return to IDLE.
- `upload_start` while busy is ignored; base and len inputs are not re-sampled.
- Reset (any state, mid-byte included): FSM→IDLE; `sram_ce`=0, `sram_addr`=0, `tx_start`=0, `tx_data`=0x00, `upload_busy`=0, `upload_done`=0, checksum=0. A byte already in flight in the transmitter is not this block's concern.

## Timing
- Start accepted at cycle N: `upload_busy`=1 and `sram_ce`=1 at N+1, capture at N+2, first `tx_start` at N+3 if `tx_busy`=0.
- Each subsequent word: RD follows the last TX_WAIT exit by one cycle (NEXT).
- Minimum spacing between consecutive `tx_start` pulses is 3 cycles plus the transmitter busy time.
- `upload_done` fires 2 cycles after the final byte's `tx_busy` fall (NEXT, then DONE).
- `upload_busy` falls in the same cycle `upload_done` is high.

## Configuration
- `DSU_UPLOAD_CHECKSUM_EN` defined: an 8-bit running sum (mod 256) of every transmitted data byte. After the last word, one extra byte equal to that sum is sent using the same ARM/GAP/WAIT handshake, then DONE. The sum is cleared on an accepted start. len==0 sends nothing.
- Not defined: no checksum logic; NEXT goes straight to DONE.

## Structure
- FSM state encoding and the byte-count constant (4 bytes per word) go in the shared DSU definitions include alongside the existing `dsu_` reset macros.
- Single module with no sub-modules. The transmitter is instantiated by the parent, not here.

## Test plan
- base=0x010, len=1, SRAM[0x010]=0x12345678 → bytes 0x12,0x34,0x56,0x78 in order, one `sram_ce` at address 0x010, then a single `upload_done`.
- base=0x1FFF, len=2 (ADDR_BW=13) → reads addresses 0x1FFF then 0x0000 (wrap-around); 8 bytes sent.
- len=0 → `upload_done` at N+1, no `sram_ce`, no `tx_start`.
- `tx_busy` held high 5 cycles at start → first `tx_start` is delayed until `tx_busy`=0; a second `upload_start` during the transfer is ignored (same byte count).
- `rst` asserted during the second byte of a word → all outputs return to reset values immediately; a new start re-runs from base.
- With `DSU_UPLOAD_CHECKSUM_EN`, words 0x01020304 and 0xFF000000 → 9th byte is 0x09.

Source files
------------

// File: rtl/dsu_sram_upload_pkg.sv
// rtl/dsu_sram_upload_pkg.sv - shared DSU upload FSM encoding and word/byte constants
package dsu_sram_upload_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_TX_ARM,
        ST_TX_GAP,
        ST_TX_WAIT,
        ST_NEXT,
        ST_CSUM,
        ST_CSUM_GAP,
        ST_CSUM_WAIT,
        ST_DONE
    } upload_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/dsu_sram_upload.sv
// rtl/dsu_sram_upload.sv - SRAM block reader streaming big-endian bytes to the DSU UART Tx
// Optional trailing checksum byte: DSU_UPLOAD_CHECKSUM_EN
module dsu_sram_upload
    import dsu_sram_upload_pkg::*;
#(
    parameter int ADDR_BW = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               upload_start,
    input  logic [ADDR_BW-1:0] upload_base,
    input  logic [ADDR_BW:0]   upload_len,
    output logic               sram_ce,
    output logic [ADDR_BW-1:0] sram_addr,
    input  logic [31:0]        sram_rdata,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic               upload_busy,
    output logic               upload_done
);

    upload_state_t      state, state_nx;
    logic [ADDR_BW-1:0] addr;
    logic [ADDR_BW:0]   remaining;
    logic [31:0]        shift;
    logic [1:0]         idx;
    logic               last_word;

    assign last_word = (remaining == (ADDR_BW+1)'(1));
    assign sram_addr = addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        sram_ce     = 1'b0;
        tx_start    = 1'b0;
        upload_done = 1'b0;
        upload_busy = (state != ST_IDLE) && (state != ST_DONE);
        case (state)
            ST_IDLE: begin
                if (upload_start) begin
                    state_nx = (upload_len == '0) ? ST_DONE : ST_RD;
                end
            end
            ST_RD: begin
                sram_ce  = 1'b1;
                state_nx = ST_CAP;
            end
            ST_CAP: state_nx = ST_TX_ARM;
            ST_TX_ARM: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_nx = ST_TX_GAP;
                end
            end
            // Transmitter raises busy one cycle late, so this cycle must not sample it
            ST_TX_GAP: state_nx = ST_TX_WAIT;
            ST_TX_WAIT: begin
                if (!tx_busy) begin
                    state_nx = (idx == LAST_BYTE_IDX) ? ST_NEXT : ST_TX_ARM;
                end
            end
            ST_NEXT: begin
`ifdef DSU_UPLOAD_CHECKSUM_EN
                state_nx = last_word ? ST_CSUM : ST_RD;
`else
                state_nx = last_word ? ST_DONE : ST_RD;
`endif
            end
`ifdef DSU_UPLOAD_CHECKSUM_EN
            ST_CSUM: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_nx = ST_CSUM_GAP;
                end
            end
            ST_CSUM_GAP: state_nx = ST_CSUM_WAIT;
            ST_CSUM_WAIT: begin
                if (!tx_busy) begin
                    state_nx = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                upload_done = 1'b1;
                state_nx    = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

`ifdef DSU_UPLOAD_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_phase;

    assign csum_phase = (state == ST_CSUM) || (state == ST_CSUM_GAP) || (state == ST_CSUM_WAIT);
    assign tx_data    = csum_phase ? csum : shift[31:24];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= 8'h00;
        end else if (state == ST_IDLE && upload_start) begin
            csum <= 8'h00;
        end else if (state == ST_TX_ARM && !tx_busy) begin
            csum <= csum + shift[31:24];
        end
    end
`else
    assign tx_data = shift[31:24];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr      <= '0;
            remaining <= '0;
            shift     <= '0;
            idx       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (upload_start) begin
                        addr      <= upload_base;
                        remaining <= upload_len;
                    end
                end
                ST_CAP: begin
                    shift <= sram_rdata;
                    idx   <= '0;
                end
                ST_TX_WAIT: begin
                    if (!tx_busy) begin
                        shift <= {shift[23:0], 8'h00};
                        if (idx != LAST_BYTE_IDX) begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                ST_NEXT: begin
                    addr      <= addr + ADDR_BW'(1);
                    remaining <= remaining - (ADDR_BW+1)'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dsu_sram_upload.sv
// tb/tb_dsu_sram_upload.sv - randomized self-checking bench with SRAM, UART Tx and byte-stream models
module tb_dsu_sram_upload;

    localparam int AW = 13;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          upload_start = 1'b0;
    logic [AW-1:0] upload_base = '0;
    logic [AW:0]   upload_len = '0;
    logic          sram_ce;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_rdata = '0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy = 1'b0;
    logic          upload_busy;
    logic          upload_done;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [DEPTH];
    logic [7:0]  byte_q [$];
    logic [7:0]  exp_b [$];
    int          addr_q [$];
    int          exp_a [$];
    int          done_cnt = 0;
    int          cyc = 0;
    int          first_tx_cyc = -1;
    int          bcnt = 0;
    int          ext_cnt = 0;
    bit          start_pend = 0;
    bit          have_last = 0;
    logic [7:0]  last_tx = '0;
    bit          cur_ce = 0;
    int          cur_addr = 0;

    dsu_sram_upload #(.ADDR_BW(AW)) dut (
        .clk(clk), .rst(rst),
        .upload_start(upload_start), .upload_base(upload_base), .upload_len(upload_len),
        .sram_ce(sram_ce), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .upload_busy(upload_busy), .upload_done(upload_done)
    );

    always #5 clk = ~clk;

    // Environment: +1 drives SRAM data / Tx busy, +2 samples DUT outputs
    initial begin
        forever begin
            @(posedge clk);
            #1;
            sram_rdata = cur_ce ? mem[cur_addr] : $urandom();
            if (start_pend) begin
                bcnt = $urandom_range(1, 4);
                start_pend = 0;
            end
            if (bcnt > 0) begin
                tx_busy = 1'b1;
                bcnt--;
            end else if (ext_cnt > 0) begin
                tx_busy = 1'b1;
                ext_cnt--;
            end else begin
                tx_busy = 1'b0;
            end
            #1;
            cyc++;
            cur_ce = sram_ce;
            cur_addr = int'(sram_addr);
            if (sram_ce) addr_q.push_back(int'(sram_addr));
            if (tx_start) begin
                if (tx_busy) begin
                    failures++;
                    $display("FAIL tx_start_while_busy tx_busy=%0b required=0", tx_busy);
                end
                byte_q.push_back(tx_data);
                if (first_tx_cyc < 0) first_tx_cyc = cyc;
                start_pend = 1;
                have_last = 1;
                last_tx = tx_data;
            end else begin
                if (tx_busy && have_last) begin
                    checks++;
                    if (tx_data !== last_tx) begin
                        failures++;
                        $display("FAIL tx_data_stable got=%02h required=%02h", tx_data, last_tx);
                    end
                end
                if (!tx_busy) have_last = 0;
            end
            if (upload_done) done_cnt++;
        end
    end

    // Reference: len words from base (wrapping), each sent MSB byte first, optional sum byte
    function automatic void build_expected(input int b, input int l);
        logic [7:0] sum;
        logic [31:0] w;
        exp_b.delete();
        exp_a.delete();
        sum = 8'h00;
        for (int i = 0; i < l; i++) begin
            exp_a.push_back((b + i) % DEPTH);
            w = mem[(b + i) % DEPTH];
            for (int k = 3; k >= 0; k--) begin
                exp_b.push_back(w[k*8 +: 8]);
                sum = sum + w[k*8 +: 8];
            end
        end
`ifdef DSU_UPLOAD_CHECKSUM_EN
        if (l > 0) exp_b.push_back(sum);
`endif
    endfunction

    function automatic string bstr(input logic [7:0] q [$]);
        string s = "";
        foreach (q[i]) s = $sformatf("%s%02h ", s, q[i]);
        return s;
    endfunction

    function automatic string astr(input int q [$]);
        string s = "";
        foreach (q[i]) s = $sformatf("%s%04h ", s, q[i]);
        return s;
    endfunction

    task automatic clear_mon();
        byte_q.delete();
        addr_q.delete();
        done_cnt = 0;
        first_tx_cyc = -1;
    endtask

    task automatic start_upload(input int b, input int l);
        @(posedge clk);
        #3;
        upload_start = 1'b1;
        upload_base = AW'(b);
        upload_len = (AW+1)'(l);
        @(posedge clk);
        #3;
        upload_start = 1'b0;
        upload_base = AW'($urandom());
        upload_len = (AW+1)'($urandom_range(1, 9));
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk);
            #3;
            n++;
        end
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s_done_count got=%0d required=1", name, done_cnt);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if ({sram_ce, tx_start, upload_busy, upload_done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=0000", {sram_ce, tx_start, upload_busy, upload_done});
        end
        checks++;
        if (sram_addr !== '0) begin
            failures++;
            $display("FAIL reset_addr got=%h required=0", sram_addr);
        end
        checks++;
        if (tx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_tx_data got=%h required=00", tx_data);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        string gs, es;
        mem[16] = 32'h12345678;
        clear_mon();
        start_upload(16, 1);
        checks++;
        if ({upload_busy, sram_ce} !== 2'b11 || sram_addr !== AW'(16)) begin
            failures++;
            $display("FAIL basic_first_cycle got=busy%b ce%b addr%h required=busy1 ce1 addr0010",
                     upload_busy, sram_ce, sram_addr);
        end
        wait_done("basic");
        build_expected(16, 1);
        gs = bstr(byte_q); es = bstr(exp_b);
        checks++;
        if (gs != es || byte_q.size() < 4) begin
            failures++;
            $display("FAIL basic_bytes got=%s required=%s", gs, es);
        end else begin
            checks++;
            if ({byte_q[0], byte_q[1], byte_q[2], byte_q[3]} !== 32'h12345678) begin
                failures++;
                $display("FAIL basic_order got=%02h%02h%02h%02h required=12345678",
                         byte_q[0], byte_q[1], byte_q[2], byte_q[3]);
            end
        end
        gs = astr(addr_q); es = astr(exp_a);
        checks++;
        if (gs != es) begin
            failures++;
            $display("FAIL basic_addrs got=%s required=%s", gs, es);
        end
    endtask

    task automatic test_wrap();
        string gs, es;
        clear_mon();
        start_upload(13'h1FFF, 2);
        wait_done("wrap");
        build_expected(13'h1FFF, 2);
        gs = astr(addr_q);
        checks++;
        if (gs != "1fff 0000 ") begin
            failures++;
            $display("FAIL wrap_addrs got=%s required=1fff 0000 ", gs);
        end
        gs = bstr(byte_q); es = bstr(exp_b);
        checks++;
        if (gs != es) begin
            failures++;
            $display("FAIL wrap_bytes got=%s required=%s", gs, es);
        end
    endtask

    task automatic test_len_zero();
        clear_mon();
        start_upload($urandom_range(0, DEPTH - 1), 0);
        checks++;
        if ({upload_done, upload_busy} !== 2'b10) begin
            failures++;
            $display("FAIL len0_first_cycle got=done%b busy%b required=done1 busy0", upload_done, upload_busy);
        end
        repeat (20) @(posedge clk);
        #3;
        checks++;
        if (addr_q.size() != 0 || byte_q.size() != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL len0_activity got=ce%0d tx%0d done%0d required=ce0 tx0 done1",
                     addr_q.size(), byte_q.size(), done_cnt);
        end
    endtask

    task automatic test_busy_hold();
        string gs, es;
        int c1, b, l;
        b = $urandom_range(0, DEPTH - 1);
        l = 2;
        clear_mon();
        start_upload(b, l);
        c1 = cyc;
        ext_cnt = 5;
        repeat (12) @(posedge clk);
        #3;
        upload_start = 1'b1;
        @(posedge clk);
        #3;
        upload_start = 1'b0;
        wait_done("busy_hold");
        checks++;
        if (first_tx_cyc != c1 + 6) begin
            failures++;
            $display("FAIL busy_hold_first_tx got=%0d required=%0d", first_tx_cyc - c1, 6);
        end
        build_expected(b, l);
        gs = bstr(byte_q); es = bstr(exp_b);
        checks++;
        if (gs != es) begin
            failures++;
            $display("FAIL busy_hold_bytes got=%s required=%s", gs, es);
        end
    endtask

    task automatic test_reset_mid();
        string gs, es;
        int b, n;
        b = $urandom_range(0, DEPTH - 1);
        clear_mon();
        start_upload(b, 2);
        n = 0;
        while (byte_q.size() < 2 && n < 500) begin
            @(posedge clk);
            #3;
            n++;
        end
        checks++;
        if (byte_q.size() < 2) begin
            failures++;
            $display("FAIL reset_mid_reach got=%0d required=2", byte_q.size());
        end
        rst = 1'b0;
        have_last = 0;
        #1;
        checks++;
        if ({sram_ce, tx_start, upload_busy, upload_done, sram_addr, tx_data} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got=ce%b st%b busy%b done%b addr%h data%h required=all0",
                     sram_ce, tx_start, upload_busy, upload_done, sram_addr, tx_data);
        end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        clear_mon();
        start_upload(b, 2);
        wait_done("reset_rerun");
        build_expected(b, 2);
        gs = bstr(byte_q); es = bstr(exp_b);
        checks++;
        if (gs != es) begin
            failures++;
            $display("FAIL reset_rerun_bytes got=%s required=%s", gs, es);
        end
        gs = astr(addr_q); es = astr(exp_a);
        checks++;
        if (gs != es) begin
            failures++;
            $display("FAIL reset_rerun_addrs got=%s required=%s", gs, es);
        end
    endtask

    task automatic test_random();
        string gs, es;
        int b, l;
        for (int t = 0; t < 6; t++) begin
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, 5);
            clear_mon();
            start_upload(b, l);
            wait_done("random");
            build_expected(b, l);
            gs = bstr(byte_q); es = bstr(exp_b);
            checks++;
            if (gs != es) begin
                failures++;
                $display("FAIL random%0d_bytes got=%s required=%s", t, gs, es);
            end
            gs = astr(addr_q); es = astr(exp_a);
            checks++;
            if (gs != es) begin
                failures++;
                $display("FAIL random%0d_addrs got=%s required=%s", t, gs, es);
            end
        end
    endtask

`ifdef DSU_UPLOAD_CHECKSUM_EN
    task automatic test_checksum();
        mem[100] = 32'h01020304;
        mem[101] = 32'hFF000000;
        clear_mon();
        start_upload(100, 2);
        wait_done("checksum");
        checks++;
        if (byte_q.size() != 9) begin
            failures++;
            $display("FAIL checksum_count got=%0d required=9", byte_q.size());
        end else begin
            checks++;
            if (byte_q[8] !== 8'h09) begin
                failures++;
                $display("FAIL checksum_byte got=%02h required=09", byte_q[8]);
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
        test_reset();
        test_basic();
        test_wrap();
        test_len_zero();
        test_busy_hold();
        test_reset_mid();
        test_random();
`ifdef DSU_UPLOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
